// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush controller: per-stage hold
// codes, FSM state encodings and the bundled hold vector.
package pipe_ctrl_pkg;

  localparam int HOLDPIP_BUS_W = 2;

  // Per-stage hold code driven to the PC and every pipeline register.
  typedef enum logic [HOLDPIP_BUS_W-1:0] {
    HOLD_NONE  = 2'b00,  // advance normally
    HOLD_WAIT  = 2'b01,  // keep current contents
    HOLD_FLUSH = 2'b10   // load the stage default (NOP bubble)
  } hold_t;

  // Controller state: RUN, or REFILL for the one fetch cycle after a redirect.
  typedef enum logic {
    PCTL_RUN    = 1'b0,
    PCTL_REFILL = 1'b1
  } pctl_state_t;

  // All five hold codes, PC first, then the registers in pipeline order.
  typedef struct packed {
    hold_t pc;
    hold_t if_id;
    hold_t id_ex;
    hold_t ex_mem;
    hold_t mem_wb;
  } hold_vec_t;

  // Every stage advances.
  function automatic hold_vec_t hold_vec_idle();
    hold_vec_t v;
    v.pc     = HOLD_NONE;
    v.if_id  = HOLD_NONE;
    v.id_ex  = HOLD_NONE;
    v.ex_mem = HOLD_NONE;
    v.mem_wb = HOLD_NONE;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for the pipeline controller: cycles with the PC held
// and number of redirects issued. Both wrap modulo 2^CNT_W.
module pipe_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cnt
);

  // Free-running event counters, cleared by reset, natural wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc) flush_cnt    <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central hold/flush controller for the five-stage core pipeline.
// Resolves stall/redirect requests by strict priority
// (mem wait > ex busy > ex jump > load-use > fetch wait) and tracks the
// one-cycle ROM refill after every redirect.
// Optional: define PIPE_CTRL_PERF_EN to add the stall/flush counters.
//
// Handshake: there is no valid/ready pair here; every request input is a
// level that is re-evaluated each cycle, and a request stays asserted until
// the pipeline advances past it (a held ex_jump_i is accepted on the first
// cycle in which no higher-priority stall is active).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_bus_wait_i,
  input  logic              load_use_i,
  input  logic              ex_busy_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              mem_bus_wait_i,
  output hold_t             hold_pc_o,
  output hold_t             hold_if_id_o,
  output hold_t             hold_id_ex_o,
  output hold_t             hold_ex_mem_o,
  output hold_t             hold_mem_wb_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output pctl_state_t       state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  hold_vec_t         hold;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              ex_stalled;

  // EX (and everything behind it) is frozen by either of these two stalls.
  assign ex_stalled = mem_bus_wait_i | ex_busy_i;

  // Priority resolution of the requests, plus the REFILL flush of if_id.
  always_comb begin
    hold      = hold_vec_idle();
    jump_en   = 1'b0;
    jump_addr = '0;
    if (mem_bus_wait_i) begin
      hold.pc     = HOLD_WAIT;
      hold.if_id  = HOLD_WAIT;
      hold.id_ex  = HOLD_WAIT;
      hold.ex_mem = HOLD_WAIT;
      hold.mem_wb = HOLD_FLUSH;
    end else if (ex_busy_i) begin
      hold.pc     = HOLD_WAIT;
      hold.if_id  = HOLD_WAIT;
      hold.id_ex  = HOLD_WAIT;
      hold.ex_mem = HOLD_FLUSH;
    end else if (ex_jump_i) begin
      // A coincident load-use is dropped: its instruction is being squashed.
      jump_en     = 1'b1;
      jump_addr   = ex_jump_addr_i;
      hold.if_id  = HOLD_FLUSH;
      hold.id_ex  = HOLD_FLUSH;
    end else if (load_use_i) begin
      hold.pc     = HOLD_WAIT;
      hold.if_id  = HOLD_WAIT;
      hold.id_ex  = HOLD_FLUSH;
    end else if (if_bus_wait_i) begin
      hold.pc     = HOLD_WAIT;
      hold.if_id  = HOLD_FLUSH;
    end
    // The word fetched during REFILL is from the old path; drop it unless
    // the pipeline is frozen, in which case if_id already waits.
    if (state == PCTL_REFILL && !ex_stalled) begin
      hold.if_id = HOLD_FLUSH;
    end
    // Reset forces a quiet pipeline regardless of the requests.
    if (rst) begin
      hold      = hold_vec_idle();
      jump_en   = 1'b0;
      jump_addr = '0;
    end
  end

  assign hold_pc_o     = hold.pc;
  assign hold_if_id_o  = hold.if_id;
  assign hold_id_ex_o  = hold.id_ex;
  assign hold_ex_mem_o = hold.ex_mem;
  assign hold_mem_wb_o = hold.mem_wb;
  assign jump_en_o     = jump_en;
  assign jump_addr_o   = jump_addr;

  // RUN/REFILL tracker: enter REFILL on every accepted jump, leave on the
  // first unstalled cycle without a new jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PCTL_RUN;
    end else begin
      case (state)
        PCTL_RUN: begin
          if (jump_en) state <= PCTL_REFILL;
        end
        PCTL_REFILL: begin
          if (jump_en)          state <= PCTL_REFILL;
          else if (!ex_stalled) state <= PCTL_RUN;
        end
        default: state <= PCTL_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_inc    (hold.pc == HOLD_WAIT),
    .flush_inc    (jump_en),
    .stall_cycles (stall_cycles_o),
    .flush_cnt    (flush_cnt_o)
  );
`else
  // Counter width only matters when the counters exist.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a table of per-cycle input/expected
// records covering reset, each priority level, redirect + REFILL, stalls
// during REFILL and reset mid-REFILL. Expected words go through a queue
// between the driver and the checker. With PIPE_CTRL_PERF_EN the counters
// are built narrow so the stall counter wraps within the table.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int ADDR_W = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 32;
`endif
  localparam int EXP_W = 10 + 1 + ADDR_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_bus_wait_i, load_use_i, ex_busy_i, ex_jump_i, mem_bus_wait_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  hold_t             hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  pctl_state_t       state;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0]  stall_cycles_o, flush_cnt_o;
`endif

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_bus_wait_i  (if_bus_wait_i),
    .load_use_i     (load_use_i),
    .ex_busy_i      (ex_busy_i),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .mem_bus_wait_i (mem_bus_wait_i),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .hold_ex_mem_o  (hold_ex_mem_o),
    .hold_mem_wb_o  (hold_mem_wb_o),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .state          (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic              rst, memw, busy, jmp, lu, ifw;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        hold;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic              je;
    logic              st;     // 0 = RUN, 1 = REFILL
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic mw, input logic bz, input logic jp,
                     input logic lu, input logic iw, input logic [ADDR_W-1:0] a,
                     input logic [9:0] h, input logic je, input logic st);
    vec_t v;
    v.rst = r; v.memw = mw; v.busy = bz; v.jmp = jp; v.lu = lu; v.ifw = iw;
    v.addr = a; v.hold = h; v.je = je; v.st = st;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic drive(input vec_t v);
    rst            = v.rst;
    mem_bus_wait_i = v.memw;
    ex_busy_i      = v.busy;
    ex_jump_i      = v.jmp;
    load_use_i     = v.lu;
    if_bus_wait_i  = v.ifw;
    ex_jump_addr_i = v.addr;
    exp_q.push_back({v.hold, v.je, (v.je ? v.addr : {ADDR_W{1'b0}}), v.st});
  endtask

  task automatic check_out(input int idx);
    logic [EXP_W-1:0] exp_w, got_w;
    exp_w = exp_q.pop_front();
    got_w = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o,
             jump_en_o, jump_addr_o, state};
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL vec%0d got=%h exp=%h (hold,jump_en,jump_addr,state)", idx, got_w, exp_w);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] exp_stall, exp_flush;

  task automatic check_cnt(input int idx);
    checks++;
    if (stall_cycles_o !== exp_stall) begin
      errors++;
      $display("FAIL stall_cnt vec%0d got=%0d exp=%0d", idx, stall_cycles_o, exp_stall);
    end
    checks++;
    if (flush_cnt_o !== exp_flush) begin
      errors++;
      $display("FAIL flush_cnt vec%0d got=%0d exp=%0d", idx, flush_cnt_o, exp_flush);
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    //   rst mw bz jp lu iw addr          hold {pc,ifid,idex,exmem,memwb}  je st
    add(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 10'b00_00_00_00_00, 0, 0); // reset, all active
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0); // idle
    add(0, 0, 0, 0, 1, 0, 32'h0,         10'b01_01_10_00_00, 0, 0); // load-use
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0000_0100, 10'b00_10_10_00_00, 1, 0); // jump
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_10_00_00_00, 0, 1); // REFILL
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 32'h0000_0200, 10'b01_01_01_10_00, 0, 0); // jump blocked x3
    add(0, 0, 1, 1, 0, 0, 32'h0000_0200, 10'b01_01_01_10_00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 32'h0000_0200, 10'b01_01_01_10_00, 0, 0);
    add(0, 0, 0, 1, 0, 0, 32'h0000_0200, 10'b00_10_10_00_00, 1, 0); // single pulse
    add(0, 1, 0, 0, 0, 0, 32'h0,         10'b01_01_01_01_10, 0, 1); // mem wait in REFILL x2
    add(0, 1, 0, 0, 0, 0, 32'h0,         10'b01_01_01_01_10, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_10_00_00_00, 0, 1); // deferred REFILL flush
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0,         10'b01_10_00_00_00, 0, 0); // fetch wait
    add(0, 0, 0, 1, 0, 0, 32'h0000_0300, 10'b00_10_10_00_00, 1, 0); // jump
    add(0, 0, 0, 1, 0, 0, 32'h0000_0400, 10'b00_10_10_00_00, 1, 1); // jump in REFILL
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_10_00_00_00, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0);
    add(0, 0, 0, 1, 1, 0, 32'h0000_0500, 10'b00_10_10_00_00, 1, 0); // jump beats load-use
    add(1, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 1); // reset mid-REFILL
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0); // REFILL abandoned
    add(0, 1, 1, 1, 1, 1, 32'h0000_0600, 10'b01_01_01_01_10, 0, 0); // mem wait wins all
    add(0, 0, 0, 0, 1, 1, 32'h0,         10'b01_01_10_00_00, 0, 0); // load-use beats fetch
    for (int k = 0; k < 7; k++)
      add(0, 0, 0, 0, 1, 0, 32'h0,       10'b01_01_10_00_00, 0, 0); // stall burst
    add(0, 0, 0, 0, 0, 0, 32'h0,         10'b00_00_00_00_00, 0, 0);

    // Reset with idle inputs for two edges before the table starts.
    rst = 1'b1; mem_bus_wait_i = 1'b0; ex_busy_i = 1'b0; ex_jump_i = 1'b0;
    load_use_i = 1'b0; if_bus_wait_i = 1'b0; ex_jump_addr_i = '0;
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = '0;
    exp_flush = '0;
`endif
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      #4;
      check_out(i);
`ifdef PIPE_CTRL_PERF_EN
      check_cnt(i);
      if (vecs[i].rst) begin
        exp_stall = '0;
        exp_flush = '0;
      end else begin
        if (vecs[i].hold[9:8] == 2'b01) exp_stall = exp_stall + 1'b1;
        if (vecs[i].je) exp_flush = exp_flush + 1'b1;
      end
`endif
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hold/flush controller for the five-stage core pipeline. Collects stall and redirect requests from IF, ID, EX and MEM. Issues a per-stage hold code to the PC register and to each pipeline register (if_id, id_ex, ex_mem, mem_wb), and drives the PC redirect for a resolved jump or mispredict. It tracks the synchronous-ROM refill cycle after a redirect.

## Interface
Parameters:
- ADDR_W, 32, instruction address width (matches `inst_addr_bus_width`)
- CNT_W, 32, performance counter width (used only with `PIPE_CTRL_PERF_EN`)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_bus_wait_i  in  1  instruction fetch not returned this cycle
- load_use_i  in  1  ID detected a load-use hazard against the instruction in EX
- ex_busy_i  in  1  multi-cycle operation (div/mul) occupying EX
- ex_jump_i  in  1  EX resolved a taken jump or a branch mispredict
- ex_jump_addr_i  in  ADDR_W  redirect target
- mem_bus_wait_i  in  1  data bus has not completed the MEM access
- hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o, hold_mem_wb_o  out  `holdpip_bus` (2)  per-stage hold code
- jump_en_o  out  1  load PC with jump_addr_o this cycle
- jump_addr_o  out  ADDR_W  redirect target
- stall_cycles_o, flush_cnt_o  out  CNT_W  performance counters (present only with `PIPE_CTRL_PERF_EN`)

## Operation
- Hold codes: `hold_none` = 2'b00 (advance), `hold_wait` = 2'b01 (keep contents), `hold_flush` = 2'b10 (load the stage default, i.e. a NOP bubble).
- Requests are resolved combinationally from the inputs and the FSM state. Strict priority, highest first:
  - **mem_bus_wait_i:** pc, if_id, id_ex and ex_mem get wait; mem_wb gets flush.
  - **ex_busy_i:** pc, if_id and id_ex get wait; ex_mem gets flush; mem_wb gets none.
  - **ex_jump_i:** jump_en_o = 1 and jump_addr_o = ex_jump_addr_i. if_id and id_ex get flush; all other stages get none. A simultaneous load_use_i is discarded, because the hazarding instruction is squashed.
  - **load_use_i:** pc and if_id get wait; id_ex gets flush.
  - **if_bus_wait_i:** pc gets wait; if_id gets flush.
  - **otherwise:** all stages get none.
- Whenever jump_en_o is 0, jump_addr_o = 0.
- A jump is accepted only when no higher-priority stall is active. While EX is held, ex_jump_i stays asserted and is accepted on the first unstalled cycle. Exactly one jump_en_o pulse is produced per accepted jump, because the id_ex flush removes the source.
- FSM states:
  - **RUN:** RUN → REFILL on an accepted jump.
  - **REFILL:** the instruction fetched in this cycle belongs to the old path, so if_id is forced to flush on top of the priority result. This forcing is overridden by mem_bus_wait_i and ex_busy_i, which put if_id in wait and keep the FSM in REFILL. Exit REFILL → RUN on the first cycle where neither stall is active. A new accepted jump in REFILL issues a redirect and stays in REFILL.
- During rst: all hold outputs = `hold_none`, jump_en_o = 0, jump_addr_o = 0, state = RUN, counters = 0. Reset mid-stall or mid-REFILL abandons the state immediately.

## Timing
- Hold outputs and jump_en_o are combinational, with same-cycle effect on the pipeline registers at the next edge. The FSM adds one registered cycle (REFILL) after each redirect.
- Redirect latency: ex_jump_i seen in cycle N → PC loads the target at edge N+1 → the first target instruction enters if_id at edge N+2 (the REFILL cycle is flushed).
- Stalls have no minimum or maximum length. A mem_bus_wait_i held for K cycles produces exactly K mem_wb bubbles.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - stall_cycles_o increments on every cycle in which hold_pc_o == `hold_wait`.
  - flush_cnt_o increments on every jump_en_o pulse.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Not defined: both counter ports and their logic are absent.

## Structure
- Shared header `rtl/core/define.v` holds `hold_none`, `hold_wait`, `hold_flush`, `holdpip_bus`, and the FSM state encodings `pctl_run` and `pctl_refill`.
- One sub-module, `pipe_ctrl_perf`, holds the two counters. It is instantiated only under `PIPE_CTRL_PERF_EN`.

## Test plan
- **Reset:** rst=1 with all inputs active → all hold = 00, jump_en_o = 0. After release with idle inputs, holds stay 00.
- **Load-use:** load_use_i=1 for one cycle → pc = 01, if_id = 01, id_ex = 10, others 00. The next cycle is all 00.
- **Jump:** ex_jump_i=1, addr 0x0000_0100 → jump_en_o = 1, jump_addr_o = 0x100, if_id = id_ex = 10. The next cycle (REFILL) has if_id = 10 and jump_en_o = 0. The cycle after that is all 00.
- **Jump blocked by multi-cycle op:** ex_busy_i=1 for 3 cycles with ex_jump_i=1 held → jump_en_o = 0 and ex_mem = 10 for those 3 cycles. Then a single jump_en_o pulse follows on cycle 4.
- **Memory wait during REFILL:** mem_bus_wait_i=1 for 2 cycles in REFILL → if_id = 01 and mem_wb = 10 for 2 cycles. Then one REFILL flush cycle follows, then RUN.
- **Perf counters (macro on):** 5 load-use stalls and 2 jumps → stall_cycles_o = 5, flush_cnt_o = 2. Preload the counters near 2^CNT_W−1 → verify wrap to 0.
